// File: rtl/chip8_draw_sequencer_if.sv
// Signal bundle between the CHIP-8 draw sequencer and its host, sprite memory,
// display engine and framebuffer-clear logic.
interface chip8_draw_sequencer_if;
    // Handshakes (cmd, rsp): a transfer happens on a rising clk edge where valid && ready;
    // the source holds valid and its payload stable until that edge and may not withdraw it.
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_i;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        disp_draw;
    logic [5:0]  disp_x;
    logic [4:0]  disp_y;
    logic [3:0]  disp_row;
    logic [7:0]  disp_sprite;
    logic        disp_done;
    logic        disp_collision;
    logic        fb_clear;
    logic        fb_clear_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_vf;
    logic        rsp_err;
    logic        busy;

    // Environment side: host, sprite memory, display engine, framebuffer.
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_i,
        output mem_rvalid, mem_rdata, disp_done, disp_collision, fb_clear_done, rsp_ready,
        input  cmd_ready, mem_req, mem_addr, disp_draw, disp_x, disp_y, disp_row, disp_sprite,
        input  fb_clear, rsp_valid, rsp_vf, rsp_err, busy
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_i,
        input  mem_rvalid, mem_rdata, disp_done, disp_collision, fb_clear_done, rsp_ready,
        output cmd_ready, mem_req, mem_addr, disp_draw, disp_x, disp_y, disp_row, disp_sprite,
        output fb_clear, rsp_valid, rsp_vf, rsp_err, busy
    );
endinterface

// File: rtl/chip8_draw_sequencer.sv
// Sequences a CHIP-8 DRW (per-row sprite fetch and display draw, collision accumulation)
// or CLS (framebuffer clear) and returns a VF/error response.
module chip8_draw_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    chip8_draw_sequencer_if.slave        bus,
    output logic [2:0]                   dbg_state
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_MEM, DRAW, WAIT_DISP, CLEAR, WAIT_CLR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [11:0] i_q;
    logic [3:0]  row_q;
    logic [7:0]  sprite_q;
    logic        vf_q, err_q;
    logic [CW-1:0] cnt_q;

    logic        cmd_ready_c, busy_c, mem_req_c, disp_draw_c, fb_clear_c, rsp_valid_c;
    logic [4:0]  row_next;
    logic        last_row, timed_out, accept;

    assign accept    = bus.cmd_valid && (state_q == IDLE);
    assign row_next  = {1'b0, row_q} + 5'd1;
    // Stop on the requested row count or when the next row would fall off the bottom (no wrap).
    assign last_row  = (row_next == {1'b0, n_q}) || (({1'b0, y_q} + {1'b0, row_next}) > 6'd31);
    assign timed_out = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        busy_c      = 1'b1;
        mem_req_c   = 1'b0;
        disp_draw_c = 1'b0;
        fb_clear_c  = 1'b0;
        rsp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_op)            state_d = CLEAR;
                    else if (bus.cmd_n == 4'd0) state_d = RESP;
                    else                       state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req_c = 1'b1;
                state_d   = WAIT_MEM;
            end
            WAIT_MEM: if (bus.mem_rvalid) state_d = DRAW;
            DRAW: begin
                disp_draw_c = 1'b1;
                state_d     = WAIT_DISP;
            end
            // A done arriving on the expiry cycle wins over the timeout.
            WAIT_DISP: begin
                if (bus.disp_done) state_d = last_row ? RESP : FETCH;
                else if (timed_out) state_d = RESP;
            end
            CLEAR: begin
                fb_clear_c = 1'b1;
                state_d    = WAIT_CLR;
            end
            WAIT_CLR: if (bus.fb_clear_done || timed_out) state_d = RESP;
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            i_q      <= '0;
            row_q    <= '0;
            sprite_q <= '0;
            vf_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    x_q   <= bus.cmd_x;
                    y_q   <= bus.cmd_y;
                    n_q   <= bus.cmd_n;
                    i_q   <= bus.cmd_i;
                    row_q <= '0;
                    vf_q  <= 1'b0;
                    err_q <= 1'b0;
                    cnt_q <= '0;
                end
                WAIT_MEM: if (bus.mem_rvalid) sprite_q <= bus.mem_rdata;
                DRAW, CLEAR: cnt_q <= '0;
                WAIT_DISP: begin
                    if (bus.disp_done) begin
                        vf_q  <= vf_q | bus.disp_collision;
                        row_q <= row_q + 4'd1;
                        cnt_q <= '0;
                    end else if (timed_out) err_q <= 1'b1;
                    else cnt_q <= cnt_q + 1'b1;
                end
                WAIT_CLR: begin
                    if (bus.fb_clear_done) cnt_q <= '0;
                    else if (timed_out) err_q <= 1'b1;
                    else cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.busy        = busy_c;
    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = i_q + {8'd0, row_q};
    assign bus.disp_draw   = disp_draw_c;
    assign bus.disp_x      = x_q;
    assign bus.disp_y      = y_q + {1'b0, row_q};
    assign bus.disp_row    = row_q;
    assign bus.disp_sprite = sprite_q;
    assign bus.fb_clear    = fb_clear_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_vf      = rsp_valid_c & vf_q;
    assign bus.rsp_err     = rsp_valid_c & err_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_chip8_draw_sequencer.sv
// Randomized scoreboard bench for chip8_draw_sequencer with memory, display and
// framebuffer responders driven from per-command latency/collision settings.
module tb_chip8_draw_sequencer;
    localparam int TIMEOUT = 8;
    localparam int HANG    = 1000;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] dbg_state;
    chip8_draw_sequencer_if bus();

    chip8_draw_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem_img [4096];
    logic [11:0] exp_mem_q  [$];
    logic [22:0] exp_draw_q [$];
    logic [1:0]  exp_rsp_q  [$];
    int          exp_clr_q  [$];

    int          cfg_mem_lat;
    int          cfg_disp_lat [16];
    logic [15:0] cfg_coll;
    int          cfg_clr_lat;
    int          gen = 0;
    bit          hold_rsp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Reference model: rows 0..n-1 are drawn until the sprite would leave the screen bottom;
    // a row whose display never answers ends the command with err and the VF gathered so far.
    task automatic push_model(input logic op, input logic [5:0] x, input logic [4:0] y,
                              input logic [3:0] n, input logic [11:0] i);
        logic vf, err;
        logic [11:0] a;
        if (op) begin
            exp_clr_q.push_back((cfg_clr_lat > TIMEOUT) ? TIMEOUT + 1 : cfg_clr_lat + 1);
            exp_rsp_q.push_back({1'b0, cfg_clr_lat > TIMEOUT});
        end else begin
            vf = 1'b0;
            err = 1'b0;
            for (int r = 0; r < int'(n) && int'(y) + r <= 31 && !err; r++) begin
                a = i + 12'(r);
                exp_mem_q.push_back(a);
                exp_draw_q.push_back({x, 5'(int'(y) + r), 4'(r), mem_img[a]});
                if (cfg_disp_lat[r] > TIMEOUT) err = 1'b1;
                else vf = vf | cfg_coll[r];
            end
            exp_rsp_q.push_back({vf, err});
        end
    endtask

    task automatic set_default_cfg();
        cfg_mem_lat = 2;
        for (int r = 0; r < 16; r++) cfg_disp_lat[r] = 3;
        cfg_coll = 16'h0000;
        cfg_clr_lat = 2;
    endtask

    task automatic run_cmd(input logic op, input logic [5:0] x, input logic [4:0] y,
                           input logic [3:0] n, input logic [11:0] i);
        int t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            fail_now("cmd_ready_wait", 64'(t));
            return;
        end
        bus.cmd_op = op;
        bus.cmd_x = x;
        bus.cmd_y = y;
        bus.cmd_n = n;
        bus.cmd_i = i;
        bus.cmd_valid = 1'b1;
        push_model(op, x, y, n, i);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x = 6'($urandom);
        bus.cmd_i = 12'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_rsp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (exp_rsp_q.size() != 0) begin
            fail_now("rsp_wait", 64'(exp_rsp_q.size()));
            exp_rsp_q.delete();
        end
        check("mem_left", 64'(exp_mem_q.size()), 0);
        check("draw_left", 64'(exp_draw_q.size()), 0);
        exp_mem_q.delete();
        exp_draw_q.delete();
    endtask

    // Sprite memory: answers each request after cfg_mem_lat wait cycles.
    int          m_g;
    logic [11:0] m_a;
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !reset) begin
                m_g = gen;
                m_a = bus.mem_addr;
                for (int k = 1; k <= cfg_mem_lat; k++) @(posedge clk);
                if (m_g == gen) begin
                    #1;
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = mem_img[m_a];
                    @(posedge clk);
                    #1;
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Display engine: done in the k-th wait cycle, collision noise whenever done is low.
    int          d_g, d_lat;
    logic        d_coll;
    logic [22:0] d_tuple;
    initial begin
        bus.disp_done = 1'b0;
        bus.disp_collision = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.disp_draw && !reset) begin
                d_g = gen;
                d_tuple = {bus.disp_x, bus.disp_y, bus.disp_row, bus.disp_sprite};
                d_lat = cfg_disp_lat[bus.disp_row];
                d_coll = cfg_coll[bus.disp_row];
                if (d_lat <= TIMEOUT) begin
                    for (int k = 1; k <= d_lat; k++) begin
                        @(posedge clk);
                        #1;
                        if (k == d_lat && d_g == gen) begin
                            bus.disp_done = 1'b1;
                            bus.disp_collision = d_coll;
                        end
                        @(negedge clk);
                        if (d_g == gen)
                            check("disp_hold", {bus.disp_x, bus.disp_y, bus.disp_row, bus.disp_sprite}, d_tuple);
                    end
                    @(posedge clk);
                    #1;
                    bus.disp_done = 1'b0;
                    bus.disp_collision = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    int c_g, c_lat;
    initial begin
        bus.fb_clear_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fb_clear && !reset) begin
                c_g = gen;
                c_lat = cfg_clr_lat;
                if (c_lat <= TIMEOUT) begin
                    for (int k = 1; k <= c_lat; k++) @(posedge clk);
                    if (c_g == gen) begin
                        #1;
                        bus.fb_clear_done = 1'b1;
                        @(posedge clk);
                        #1;
                        bus.fb_clear_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the expected queues whenever the DUT presents an event.
    logic   prev_mem, prev_draw, prev_clr, prev_rv, prev_rr, prev_vf, prev_err;
    logic   clr_pending;
    int     clr_exp;
    longint clr_cyc;
    always @(negedge clk) begin
        if (reset) begin
            prev_mem <= 1'b0; prev_draw <= 1'b0; prev_clr <= 1'b0;
            prev_rv <= 1'b0; prev_rr <= 1'b0; prev_vf <= 1'b0; prev_err <= 1'b0;
            clr_pending <= 1'b0;
        end else begin
            check("ready_vs_busy", {63'd0, bus.cmd_ready ^ bus.busy}, 1);
            if (bus.mem_req || bus.disp_draw || bus.fb_clear)
                check("pulse_onehot", 64'($countones({bus.mem_req, bus.disp_draw, bus.fb_clear})), 1);
            if (bus.mem_req) begin
                check("mem_req_width", {63'd0, prev_mem}, 0);
                if (exp_mem_q.size() == 0) fail_now("mem_req_extra", bus.mem_addr);
                else check("mem_addr", bus.mem_addr, exp_mem_q.pop_front());
            end
            if (bus.disp_draw) begin
                check("disp_draw_width", {63'd0, prev_draw}, 0);
                if (exp_draw_q.size() == 0) fail_now("disp_draw_extra", bus.disp_y);
                else check("disp_fields", {bus.disp_x, bus.disp_y, bus.disp_row, bus.disp_sprite},
                           exp_draw_q.pop_front());
            end
            if (bus.fb_clear) begin
                check("fb_clear_width", {63'd0, prev_clr}, 0);
                if (exp_clr_q.size() == 0) fail_now("fb_clear_extra", 1);
                else begin
                    clr_exp <= exp_clr_q.pop_front();
                    clr_cyc <= cyc;
                    clr_pending <= 1'b1;
                end
            end
            if (bus.rsp_valid && !prev_rv && clr_pending) begin
                check("clr_to_rsp_cycles", 64'(cyc - clr_cyc), 64'(clr_exp));
                clr_pending <= 1'b0;
            end
            if (prev_rv && !prev_rr)
                check("rsp_hold", {bus.rsp_valid, bus.rsp_vf, bus.rsp_err}, {1'b1, prev_vf, prev_err});
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp_q.size() == 0) fail_now("rsp_extra", {bus.rsp_vf, bus.rsp_err});
                else check("rsp_vf_err", {bus.rsp_vf, bus.rsp_err}, exp_rsp_q.pop_front());
            end
            prev_mem <= bus.mem_req; prev_draw <= bus.disp_draw; prev_clr <= bus.fb_clear;
            prev_rv <= bus.rsp_valid; prev_rr <= bus.rsp_ready;
            prev_vf <= bus.rsp_vf; prev_err <= bus.rsp_err;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {bus.busy, bus.mem_req, bus.disp_draw, bus.fb_clear,
                              bus.rsp_valid, bus.rsp_vf, bus.rsp_err}, 0);
        check({tag, "_data"}, {bus.mem_addr, bus.disp_x, bus.disp_y, bus.disp_row, bus.disp_sprite}, 0);
    endtask

    initial begin
        int t;
        int draws;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_n = '0;
        bus.cmd_i = '0;
        for (int a = 0; a < 4096; a++) mem_img[a] = 8'($urandom);
        set_default_cfg();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", {63'd0, bus.cmd_ready}, 1);
        check_idle_outputs("post_reset");

        // Reference sprite: latency 2, collision on row 1 only.
        cfg_coll = 16'b010;
        run_cmd(1'b0, 6'd10, 5'd5, 4'd3, 12'h200);
        wait_done();
        set_default_cfg();
        run_cmd(1'b0, 6'd20, 5'd30, 4'd5, 12'h123);   // vertical clip
        wait_done();
        run_cmd(1'b0, 6'd63, 5'd0, 4'd2, 12'hFFF);    // address wrap
        wait_done();

        // Clear timeout, clear done on the expiry cycle, draw timeout after a colliding row.
        cfg_clr_lat = HANG;
        run_cmd(1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
        wait_done();
        cfg_clr_lat = TIMEOUT;
        run_cmd(1'b1, 6'd0, 5'd0, 4'd0, 12'h000);
        wait_done();
        cfg_disp_lat[0] = TIMEOUT;
        cfg_disp_lat[1] = HANG;
        cfg_coll = 16'b01;
        run_cmd(1'b0, 6'd7, 5'd9, 4'd4, 12'h050);
        wait_done();
        set_default_cfg();

        run_cmd(1'b0, 6'd1, 5'd1, 4'd0, 12'h400);     // N=0: immediate response
        @(negedge clk);
        check("n0_immediate_rsp", {63'd0, bus.rsp_valid}, 1);
        wait_done();

        // Response backpressure with a command offered while busy.
        hold_rsp = 1'b1;
        cfg_coll = 16'b10;
        run_cmd(1'b0, 6'd33, 5'd12, 4'd2, 12'h300);
        t = 0;
        while (!bus.rsp_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rsp_valid) fail_now("bp_rsp_wait", 64'(t));
        bus.cmd_op = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_stable", {bus.rsp_valid, bus.rsp_vf, bus.rsp_err},
                  {1'b1, (exp_rsp_q.size() != 0) ? exp_rsp_q[0] : 2'b11});
            check("bp_cmd_ready", {63'd0, bus.cmd_ready}, 0);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        hold_rsp = 1'b0;
        wait_done();
        set_default_cfg();

        // Reset while waiting on the display for row 1 (row 0 already collided).
        cfg_disp_lat[0] = 1;
        cfg_disp_lat[1] = HANG;
        cfg_coll = 16'b01;
        run_cmd(1'b0, 6'd3, 5'd4, 4'd4, 12'h600);
        draws = 0;
        t = 0;
        while (draws < 2 && t < 200) begin
            @(negedge clk);
            if (bus.disp_draw) draws++;
            t++;
        end
        if (draws < 2) fail_now("rst_draw_wait", 64'(draws));
        @(negedge clk);
        reset = 1'b1;
        gen++;
        exp_mem_q.delete();
        exp_draw_q.delete();
        exp_rsp_q.delete();
        exp_clr_q.delete();
        #1;
        check_idle_outputs("midcmd_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midcmd_cmd_ready", {63'd0, bus.cmd_ready}, 1);
        set_default_cfg();
        run_cmd(1'b0, 6'd3, 5'd4, 4'd3, 12'h600);
        wait_done();
        cfg_coll = 16'b100;
        run_cmd(1'b0, 6'd3, 5'd4, 4'd3, 12'h600);
        wait_done();

        for (int c = 0; c < 60; c++) begin
            cfg_mem_lat = $urandom_range(1, 4);
            for (int r = 0; r < 16; r++)
                cfg_disp_lat[r] = ($urandom_range(0, 19) == 0) ? HANG : $urandom_range(1, TIMEOUT);
            cfg_coll = 16'($urandom);
            cfg_clr_lat = ($urandom_range(0, 3) == 0) ? HANG : $urandom_range(1, TIMEOUT);
            run_cmd(($urandom_range(0, 4) == 0),
                    6'($urandom_range(0, 63)),
                    5'(($urandom_range(0, 1) == 1) ? $urandom_range(24, 31) : $urandom_range(0, 31)),
                    4'($urandom_range(0, 15)),
                    12'(($urandom_range(0, 3) == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
